register_file_param: RTL and testbench

Parametrised register file with one write port and two read ports. It is the next generation of the 5-to-32 write-select decoder: the address decode is generalised to ADDR_BITS, and it now owns the storage it selects. The block sits in the datapath between instruction decode and the ALU. It adds behaviour the plain decoder lacks: synchronous clear, optional hard-wired zero register, and optional write-to-read bypass.

---
 rtl/register_file_param.sv | 69 ++++++
 tb/tb_register_file_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// Parametrised register file: one write port, two combinational read ports,
// one-hot write strobe, optional hard-wired zero register and write-to-read bypass.
module register_file_param #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        WrEn,
  input  logic [ADDR_BITS-1:0]        WrAddr,
  input  logic [WIDTH-1:0]            WrData,
  input  logic [ADDR_BITS-1:0]        RdAddr1,
  output logic [WIDTH-1:0]            RdData1,
  input  logic [ADDR_BITS-1:0]        RdAddr2,
  output logic [WIDTH-1:0]            RdData2,
  output logic [(1<<ADDR_BITS)-1:0]   WrSel
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             wr_zero;

  assign wr_zero = (ZERO_REG != 0) && (WrAddr == '0);

  always_comb begin
    WrSel = '0;
    if (!Rst && WrEn && !wr_zero) begin
      WrSel[WrAddr] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = WrSel[i] ? WrData : regs_q[i];
    end
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (Rst) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Zero-register masking is checked first so it overrides a bypass hit on r0.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_BITS-1:0] addr);
    logic [WIDTH-1:0] val;
    val = regs_q[addr];
    if ((ZERO_REG != 0) && (addr == '0)) begin
      val = '0;
    end else if ((BYPASS != 0) && WrEn && !Rst && (addr == WrAddr)) begin
      val = WrData;
    end
    return val;
  endfunction

  always_comb begin
    RdData1 = read_port(RdAddr1);
    RdData2 = read_port(RdAddr2);
  end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: four configurations driven with directed
// vectors, checked every cycle against an array model plus literal spot checks.
module tb_register_file_param;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;

  logic        s_we;
  logic [2:0]  s_wa;
  logic [7:0]  s_wd;
  logic [2:0]  s_ra1;
  logic [2:0]  s_ra2;

  logic [31:0] rd1_a, rd2_a, sel_a;
  logic [31:0] rd1_z, rd2_z, sel_z;
  logic [31:0] rd1_b, rd2_b, sel_b;
  logic [7:0]  rd1_s, rd2_s, sel_s;

  int n_vec;
  int n_miss;
  logic chk_en;

  // Model: one 32-entry image per configuration (a, z, b, s).
  logic [31:0] mem [4][32];
  int          zr  [4];
  int          bp  [4];

  register_file_param #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .Clk(clk), .Rst(rst), .WrEn(we), .WrAddr(wa), .WrData(wd),
    .RdAddr1(ra1), .RdData1(rd1_a), .RdAddr2(ra2), .RdData2(rd2_a), .WrSel(sel_a));

  register_file_param #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(0), .BYPASS(1)) dut_z (
    .Clk(clk), .Rst(rst), .WrEn(we), .WrAddr(wa), .WrData(wd),
    .RdAddr1(ra1), .RdData1(rd1_z), .RdAddr2(ra2), .RdData2(rd2_z), .WrSel(sel_z));

  register_file_param #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .Clk(clk), .Rst(rst), .WrEn(we), .WrAddr(wa), .WrData(wd),
    .RdAddr1(ra1), .RdData1(rd1_b), .RdAddr2(ra2), .RdData2(rd2_b), .WrSel(sel_b));

  register_file_param #(.WIDTH(8), .ADDR_BITS(3), .ZERO_REG(1), .BYPASS(1)) dut_s (
    .Clk(clk), .Rst(rst), .WrEn(s_we), .WrAddr(s_wa), .WrData(s_wd),
    .RdAddr1(s_ra1), .RdData1(rd1_s), .RdAddr2(s_ra2), .RdData2(rd2_s), .WrSel(sel_s));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [31:0] exp_rd(input int k, input int ra, input logic w_en,
                                         input int w_a, input logic [31:0] w_d, input logic r);
    if (zr[k] != 0 && ra == 0) return 32'h0;
    if (bp[k] != 0 && w_en && !r && ra == w_a) return w_d;
    return mem[k][ra];
  endfunction

  function automatic logic [31:0] exp_sel(input int k, input logic w_en, input int w_a,
                                          input logic r);
    if (r || !w_en || (zr[k] != 0 && w_a == 0)) return 32'h0;
    return 32'h1 << w_a;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        for (int j = 0; j < 32; j++) mem[k][j] = 32'h0;
      end else if (k < 3) begin
        if (we && !(zr[k] != 0 && wa == 0)) mem[k][wa] = wd;
      end else begin
        if (s_we && s_wa != 0) mem[k][s_wa] = {24'h0, s_wd};
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.rd1", rd1_a, exp_rd(0, ra1, we, wa, wd, rst));
      chk("a.rd2", rd2_a, exp_rd(0, ra2, we, wa, wd, rst));
      chk("a.sel", sel_a, exp_sel(0, we, wa, rst));
      chk("z.rd1", rd1_z, exp_rd(1, ra1, we, wa, wd, rst));
      chk("z.rd2", rd2_z, exp_rd(1, ra2, we, wa, wd, rst));
      chk("z.sel", sel_z, exp_sel(1, we, wa, rst));
      chk("b.rd1", rd1_b, exp_rd(2, ra1, we, wa, wd, rst));
      chk("b.rd2", rd2_b, exp_rd(2, ra2, we, wa, wd, rst));
      chk("b.sel", sel_b, exp_sel(2, we, wa, rst));
      chk("s.rd1", {24'h0, rd1_s}, exp_rd(3, s_ra1, s_we, s_wa, {24'h0, s_wd}, rst));
      chk("s.rd2", {24'h0, rd2_s}, exp_rd(3, s_ra2, s_we, s_wa, {24'h0, s_wd}, rst));
      chk("s.sel", {24'h0, sel_s}, exp_sel(3, s_we, s_wa, rst));
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic r, input logic w_en, input logic [4:0] w_a,
                       input logic [31:0] w_d, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst = r; we = w_en; wa = w_a; wd = w_d; ra1 = a1; ra2 = a2;
  endtask

  task automatic drive_s(input logic w_en, input logic [2:0] w_a, input logic [7:0] w_d,
                         input logic [2:0] a1, input logic [2:0] a2);
    @(posedge clk);
    #1;
    s_we = w_en; s_wa = w_a; s_wd = w_d; s_ra1 = a1; s_ra2 = a2;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec = 0; n_miss = 0; chk_en = 1'b0;
    zr[0] = 1; bp[0] = 1;
    zr[1] = 0; bp[1] = 1;
    zr[2] = 1; bp[2] = 0;
    zr[3] = 1; bp[3] = 1;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 32; j++) mem[k][j] = 32'h0;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra1 = '0; s_ra2 = '0;

    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset.a.r0", rd1_a, 32'h0);
    chk("reset.sel", sel_a, 32'h0);

    // reset clear
    drive(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd31);
    @(negedge clk);
    chk("wr7.bypass.a", rd1_a, 32'hDEADBEEF);
    chk("wr7.nobypass.b", rd1_b, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
    @(negedge clk);
    chk("rst.sel", sel_a, 32'h0);
    chk("rst.stored.r7", rd1_a, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
    @(negedge clk);
    chk("clr.r7", rd1_a, 32'h0);
    chk("clr.r31", rd2_a, 32'h0);

    // highest address
    drive(1'b0, 1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31);
    @(negedge clk);
    chk("wr31.sel", sel_a, 32'h80000000);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    @(negedge clk);
    chk("rd31.p1", rd1_b, 32'h12345678);
    chk("rd31.p2", rd2_b, 32'h12345678);

    // zero register
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    @(negedge clk);
    chk("wr0.sel.a", sel_a, 32'h0);
    chk("wr0.sel.z", sel_z, 32'h1);
    chk("wr0.rd.a", rd1_a, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    chk("rd0.a", rd1_a, 32'h0);
    chk("rd0.z", rd1_z, 32'hFFFFFFFF);

    // bypass
    drive(1'b0, 1'b1, 5'd5, 32'h11, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd5, 32'h22, 5'd5, 5'd0);
    @(negedge clk);
    chk("byp.a", rd1_a, 32'h22);
    chk("byp.b.old", rd1_b, 32'h11);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk);
    chk("byp.b.new", rd1_b, 32'h22);

    // reset versus write and bypass
    drive(1'b0, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd3, 32'hAA, 5'd3, 5'd3);
    @(negedge clk);
    chk("rstwr.rd", rd1_a, 32'h55);
    chk("rstwr.sel", sel_a, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    @(negedge clk);
    chk("rstwr.after", rd1_a, 32'h0);

    // full sweep on the 32-entry files, reading neighbours and same address
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'hA5A5A5A5 ^ (32'(i) * 32'h01010101),
            5'(i), 5'((i + 31) % 32));
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'(i), 32'h0, 5'(i), 5'(31 - i));
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // 8-deep, 8-bit configuration
    for (int i = 0; i < 8; i++) begin
      drive_s(1'b1, 3'(i), 8'(8 * i + 1), 3'(i), 3'((i + 7) % 8));
      @(negedge clk);
      chk("s.sweep.sel", {24'h0, sel_s}, (i == 0) ? 32'h0 : (32'h1 << i));
    end
    for (int i = 0; i < 8; i++) begin
      drive_s(1'b0, 3'd0, 8'h0, 3'(i), 3'(7 - i));
      @(negedge clk);
      chk("s.rb.p1", {24'h0, rd1_s}, (i == 0) ? 32'h0 : 32'(8 * i + 1));
      chk("s.rb.p2", {24'h0, rd2_s}, (i == 7) ? 32'h0 : 32'(8 * (7 - i) + 1));
    end

    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
